// File: rtl/pipe_ctrl.sv
// pipe_ctrl: decoded control-word pipeline with stall/flush and a HALT drain FSM.
//   Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, a valid illegal opcode
//   is handled like HALT and sets err. When it is undefined, illegal opcodes become
//   bubbles and err is tied to 0.
//   Ports:
//     clk, rst_n (async, active-low)
//     instr[15:0]   opcode = instr[15:11], function = instr[1:0]
//     in_valid, stall, flush
//     ex_alu_src[2:0], ex_invA, ex_invB, ex_cin   stage-1 (EX) ALU controls
//     mem_write                                   stage STAGES-1 (MEM)
//     wb_reg_write, wb_mem_to_reg, wb_reg_dst[1:0], wb_valid   stage STAGES (WB)
//     dump (one-cycle pulse when HALT reaches WB), halted, err
module pipe_ctrl #(
    parameter int STAGES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [2:0]  ex_alu_src,
    output logic        ex_invA,
    output logic        ex_invB,
    output logic        ex_cin,
    output logic        mem_write,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [1:0]  wb_reg_dst,
    output logic        wb_valid,
    output logic        dump,
    output logic        halted,
    output logic        err
);
    typedef struct packed {
        logic [2:0] alu_src;
        logic       inv_a;
        logic       inv_b;
        logic       cin;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] reg_dst;
    } ctl_t;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t     r_state, w_state_nx;
    logic [1:0] r_cnt, w_cnt_nx;
    ctl_t       r_ctl [1:STAGES];
    logic       r_v   [1:STAGES];
    logic       r_h   [1:STAGES];
    ctl_t       w_ctl;
    logic [4:0] w_op;
    logic [1:0] w_fn;
    logic       w_iv, w_ill, w_trap, w_v_in, w_h_in, w_load, w_kill, w_unused;

    assign w_op     = instr[15:11];
    assign w_fn     = instr[1:0];
    assign w_unused = ^instr[10:2];
    assign w_iv     = in_valid && r_state == RUN;
    assign w_ill    = w_op[4:1] == 4'b0001;
    assign w_v_in   = w_iv && !w_ill;
    assign w_h_in   = (w_iv && w_op == 5'b00000) || w_trap;
    assign w_load   = !stall && !flush;
    // A flush while the HALT still sits in stage 1 cancels the halt: the HALT is
    // discarded instead of advancing, and the FSM returns to RUN.
    assign w_kill   = flush && r_h[1];

`ifdef ILLEGAL_TRAP_EN
    logic r_err;
    assign w_trap = w_iv && w_ill;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else if (w_load && w_trap) r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign w_trap = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        w_ctl            = '0;
        w_ctl.alu_src    = (w_op[4:1] == 4'b0100 || w_op[4:1] == 4'b1000 || w_op == 5'b10011) ? 3'd1 :
                           (w_op[4:1] == 4'b0101 || w_op[4:2] == 3'b101) ? 3'd2 :
                           (w_op == 5'b11000) ? 3'd3 :
                           (w_op == 5'b10010) ? 3'd4 :
                           (w_op[4:2] == 3'b011) ? 3'd5 :
                           (w_op == 5'b11001 || w_op[4:2] == 3'b001) ? 3'd6 :
                           (w_op[4:1] == 4'b0000) ? 3'd7 : 3'd0;
        {w_ctl.inv_a, w_ctl.inv_b, w_ctl.cin} =
            (w_op == 5'b01001 || w_op == 5'b11101 || (w_op == 5'b11011 && w_fn == 2'b01)) ? 3'b101 :
            (w_op == 5'b01011 || (w_op == 5'b11011 && w_fn == 2'b11)) ? 3'b010 :
            (w_op == 5'b11100 || w_op == 5'b11110 || w_op[4:2] == 3'b011) ? 3'b011 : 3'b000;
        w_ctl.mem_write  = w_op == 5'b10000 || w_op == 5'b10011;
        w_ctl.mem_to_reg = w_op == 5'b10001;
        w_ctl.reg_write  = w_op[4:2] == 3'b010 || w_op[4:2] == 3'b101 || w_op == 5'b10001 ||
                           w_op == 5'b10010 || w_op == 5'b10011 || w_op[4:3] == 2'b11 ||
                           w_op[4:1] == 4'b0011;
        w_ctl.reg_dst    = (w_op[4:3] == 2'b11 && w_op != 5'b11000) ? 2'd0 :
                           (w_op[4:2] == 3'b010 || w_op[4:2] == 3'b101 || w_op == 5'b10001 ||
                            w_op[4:1] == 4'b0000) ? 2'd1 :
                           (w_op == 5'b10000 || w_op == 5'b10010 || w_op == 5'b10011 ||
                            w_op == 5'b11000 || w_op[4:2] == 3'b011) ? 2'd2 :
                           (w_op[4:2] == 3'b001) ? 2'd3 : 2'd0;
    end

    // r_h tags the HALT (or trapped illegal op) as it travels; a trapped illegal op
    // carries the tag with valid=0 so it never shows up as a real instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= STAGES; i++) begin
                r_v[i]   <= 1'b0;
                r_h[i]   <= 1'b0;
                r_ctl[i] <= '0;
            end
        end else begin
            if (flush || !stall) begin
                r_v[1]   <= w_load && w_v_in;
                r_h[1]   <= w_load && w_h_in;
                r_ctl[1] <= (w_load && w_v_in) ? w_ctl : '0;
            end
            if (!stall) begin
                for (int i = 2; i <= STAGES; i++) begin
                    r_v[i]   <= r_v[i-1] && !(i == 2 && w_kill);
                    r_h[i]   <= r_h[i-1] && !(i == 2 && w_kill);
                    r_ctl[i] <= (i == 2 && w_kill) ? '0 : r_ctl[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // The counter tracks the HALT's distance to WB; both reach WB together.
    assign dump = r_state == DRAIN && r_cnt == 2'd0 && r_h[STAGES];

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            RUN: begin
                if (w_load && w_h_in) begin
                    w_state_nx = DRAIN;
                    w_cnt_nx   = 2'(STAGES - 1);
                end
            end
            DRAIN: begin
                if (w_kill) begin
                    w_state_nx = RUN;
                    w_cnt_nx   = 2'd0;
                end else if (dump) w_state_nx = HALTED;
                else if (!stall && r_cnt != 2'd0) w_cnt_nx = r_cnt - 2'd1;
            end
            default: ;
        endcase
    end

    assign ex_alu_src    = r_v[1] ? r_ctl[1].alu_src : 3'd0;
    assign ex_invA       = r_v[1] && r_ctl[1].inv_a;
    assign ex_invB       = r_v[1] && r_ctl[1].inv_b;
    assign ex_cin        = r_v[1] && r_ctl[1].cin;
    assign mem_write     = r_v[STAGES-1] && r_ctl[STAGES-1].mem_write;
    assign wb_reg_write  = r_v[STAGES] && r_ctl[STAGES].reg_write;
    assign wb_mem_to_reg = r_v[STAGES] && r_ctl[STAGES].mem_to_reg;
    assign wb_reg_dst    = r_v[STAGES] ? r_ctl[STAGES].reg_dst : 2'd0;
    assign wb_valid      = r_v[STAGES];
    assign halted        = r_state == HALTED;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench driving a 3-stage and a 4-stage pipe_ctrl in parallel.
module tb_pipe_ctrl;
    typedef struct packed {
        logic [2:0] alu;
        logic [2:0] inv;
        logic       mw;
        logic       mr;
        logic       rw;
        logic [1:0] rd;
    } ctl_t;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [15:0] HALT = 16'h0000, ADD = 16'hD801, ADDI = 16'h4000, ST = 16'h8000, ILL = 16'h1000;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [15:0] instr = 16'h0;
    logic [2:0]  ex_alu_src3, ex_alu_src4;
    logic        ex_invA3, ex_invB3, ex_cin3, mem_write3, wb_reg_write3, wb_mem_to_reg3;
    logic        ex_invA4, ex_invB4, ex_cin4, mem_write4, wb_reg_write4, wb_mem_to_reg4;
    logic [1:0]  wb_reg_dst3, wb_reg_dst4;
    logic        wb_valid3, dump3, halted3, err3, wb_valid4, dump4, halted4, err4;
    int          tot = 0, bad = 0;
    ctl_t        q3[$], q4[$];
    ctl_t        e3, e4;
    logic        m_run = 1'b1, m_s1push = 1'b0, m_s1halt = 1'b0, adv = 1'b0;
    wire [14:0]  o3 = {ex_alu_src3, ex_invA3, ex_invB3, ex_cin3, mem_write3, wb_reg_write3, wb_mem_to_reg3,
                       wb_reg_dst3, wb_valid3, dump3, halted3, err3};
    wire [14:0]  o4 = {ex_alu_src4, ex_invA4, ex_invB4, ex_cin4, mem_write4, wb_reg_write4, wb_mem_to_reg4,
                       wb_reg_dst4, wb_valid4, dump4, halted4, err4};

    pipe_ctrl #(.STAGES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .stall(stall), .flush(flush),
        .ex_alu_src(ex_alu_src3), .ex_invA(ex_invA3), .ex_invB(ex_invB3), .ex_cin(ex_cin3),
        .mem_write(mem_write3), .wb_reg_write(wb_reg_write3), .wb_mem_to_reg(wb_mem_to_reg3),
        .wb_reg_dst(wb_reg_dst3), .wb_valid(wb_valid3), .dump(dump3), .halted(halted3), .err(err3));
    pipe_ctrl #(.STAGES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .stall(stall), .flush(flush),
        .ex_alu_src(ex_alu_src4), .ex_invA(ex_invA4), .ex_invB(ex_invB4), .ex_cin(ex_cin4),
        .mem_write(mem_write4), .wb_reg_write(wb_reg_write4), .wb_mem_to_reg(wb_mem_to_reg4),
        .wb_reg_dst(wb_reg_dst4), .wb_valid(wb_valid4), .dump(dump4), .halted(halted4), .err(err4));

    always #5 clk = ~clk;
    always @(posedge clk) adv <= !stall;

    function automatic ctl_t ref_ctl(input logic [15:0] ins);
        ctl_t c;
        logic [4:0] op;
        op = ins[15:11];
        c = '0;
        casez (op)
            5'b0000?: begin c.alu = 3'd7; c.rd = 2'd1; end
            5'b001??: begin c.alu = 3'd6; c.rd = 2'd3; c.rw = op[1]; end
            5'b0100?: begin c.alu = 3'd1; c.rd = 2'd1; c.rw = 1'b1; c.inv = op[0] ? 3'b101 : 3'b000; end
            5'b0101?: begin c.alu = 3'd2; c.rd = 2'd1; c.rw = 1'b1; c.inv = op[0] ? 3'b010 : 3'b000; end
            5'b011??: begin c.alu = 3'd5; c.rd = 2'd2; c.inv = 3'b011; end
            5'b10000: begin c.alu = 3'd1; c.rd = 2'd2; c.mw = 1'b1; end
            5'b10001: begin c.alu = 3'd1; c.rd = 2'd1; c.mr = 1'b1; c.rw = 1'b1; end
            5'b10010: begin c.alu = 3'd4; c.rd = 2'd2; c.rw = 1'b1; end
            5'b10011: begin c.alu = 3'd1; c.rd = 2'd2; c.mw = 1'b1; c.rw = 1'b1; end
            5'b101??: begin c.alu = 3'd2; c.rd = 2'd1; c.rw = 1'b1; end
            5'b11000: begin c.alu = 3'd3; c.rd = 2'd2; c.rw = 1'b1; end
            5'b11001: begin c.alu = 3'd6; c.rw = 1'b1; end
            5'b11011: begin
                c.rw  = 1'b1;
                c.inv = ins[1:0] == 2'b01 ? 3'b101 : ins[1:0] == 2'b11 ? 3'b010 : 3'b000;
            end
            5'b11100, 5'b11110: begin c.rw = 1'b1; c.inv = 3'b011; end
            5'b11101: begin c.rw = 1'b1; c.inv = 3'b101; end
            5'b11???: c.rw = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Drive one cycle; the model tracks what sits in stage 1 so flushes can retract it.
    task automatic step(input logic [15:0] ins, input logic v, input logic st, input logic fl);
        logic acc, ill;
        instr = ins; in_valid = v; stall = st; flush = fl;
        ill = ins[15:12] == 4'b0001;
        acc = v && m_run && !st && !fl;
        if (fl && m_s1push && (st || m_s1halt)) begin
            void'(q3.pop_back());
            void'(q4.pop_back());
        end
        if (fl && m_s1halt) m_run = 1'b1;
        if (fl) begin
            m_s1push = 1'b0;
            m_s1halt = 1'b0;
        end else if (!st) begin
            m_s1push = acc && !ill;
            m_s1halt = acc && (ins[15:11] == 5'b00000 || (ill && TRAP));
            if (m_s1push) begin
                q3.push_back(ref_ctl(ins));
                q4.push_back(ref_ctl(ins));
            end
            if (m_s1halt) m_run = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        q3.delete(); q4.delete();
        m_run = 1'b1; m_s1push = 1'b0; m_s1halt = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk_empty(input string name);
        tot++;
        if (q3.size() != 0 || q4.size() != 0) begin
            bad++;
            $display("FAIL %s: pending got q3=%0d q4=%0d required 0/0", name, q3.size(), q4.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && adv && wb_valid3) begin
            tot++;
            if (q3.size() == 0) begin
                bad++;
                $display("FAIL wb3_extra: got wb_valid=1 required no instruction");
            end else begin
                e3 = q3.pop_front();
                if ({wb_reg_write3, wb_mem_to_reg3, wb_reg_dst3} !== {e3.rw, e3.mr, e3.rd}) begin
                    bad++;
                    $display("FAIL wb3: got %b required %b", {wb_reg_write3, wb_mem_to_reg3, wb_reg_dst3}, {e3.rw, e3.mr, e3.rd});
                end
            end
        end
        if (rst_n && adv && wb_valid4) begin
            tot++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL wb4_extra: got wb_valid=1 required no instruction");
            end else begin
                e4 = q4.pop_front();
                if ({wb_reg_write4, wb_mem_to_reg4, wb_reg_dst4} !== {e4.rw, e4.mr, e4.rd}) begin
                    bad++;
                    $display("FAIL wb4: got %b required %b", {wb_reg_write4, wb_mem_to_reg4, wb_reg_dst4}, {e4.rw, e4.mr, e4.rd});
                end
            end
        end
    end

    task automatic test_reset();
        instr = ADD; in_valid = 1'b1;
        @(posedge clk);
        #1;
        tot++;
        if (o3 !== 15'h0 || o4 !== 15'h0) begin
            bad++;
            $display("FAIL reset_hold: got %h/%h required 0/0", o3, o4);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);
        tot++;
        if (o3 !== 15'h0 || o4 !== 15'h0) begin
            bad++;
            $display("FAIL reset_after: got %h/%h required 0/0", o3, o4);
        end
    endtask

    task automatic test_add();
        step(ADD, 1'b1, 1'b0, 1'b0);
        tot++;
        if ({ex_alu_src3, ex_invA3, ex_invB3, ex_cin3} !== 6'b000_101) begin
            bad++;
            $display("FAIL add_ex: got %b required 000101", {ex_alu_src3, ex_invA3, ex_invB3, ex_cin3});
        end
        idle(1);
        tot++;
        if (wb_valid3 !== 1'b0) begin
            bad++;
            $display("FAIL add_early: got wb_valid=%b required 0", wb_valid3);
        end
        idle(1);
        tot++;
        if ({wb_valid3, wb_reg_write3, wb_reg_dst3} !== 4'b1100) begin
            bad++;
            $display("FAIL add_wb3: got %b required 1100", {wb_valid3, wb_reg_write3, wb_reg_dst3});
        end
        idle(1);
        tot++;
        if ({wb_valid3, wb_valid4} !== 2'b01) begin
            bad++;
            $display("FAIL add_wb4: got %b required 01", {wb_valid3, wb_valid4});
        end
        idle(2);
        chk_empty("add_drain");
    endtask

    task automatic test_decode();
        logic [15:0] ins;
        logic pmw;
        ctl_t c;
        pmw = 1'b0;
        for (int op = 1; op < 32; op++) begin
            if (op == 2 || op == 3) continue;
            ins = {5'(op), 9'h0, 2'($urandom_range(0, 3))};
            c = ref_ctl(ins);
            step(ins, 1'b1, 1'b0, 1'b0);
            tot++;
            if ({ex_alu_src3, ex_invA3, ex_invB3, ex_cin3, mem_write3} !== {c.alu, c.inv, pmw}) begin
                bad++;
                $display("FAIL decode_%0d: got %b required %b", op, {ex_alu_src3, ex_invA3, ex_invB3, ex_cin3, mem_write3}, {c.alu, c.inv, pmw});
            end
            pmw = c.mw;
        end
        idle(5);
        chk_empty("decode_drain");
    endtask

    task automatic test_stall();
        step(ST, 1'b1, 1'b0, 1'b0);
        idle(1);
        tot++;
        if (mem_write3 !== 1'b1) begin
            bad++;
            $display("FAIL stall_mem0: got %b required 1", mem_write3);
        end
        for (int i = 0; i < 2; i++) begin
            step(ADD, 1'b1, 1'b1, 1'b0);
            tot++;
            if ({mem_write3, wb_valid3, ex_alu_src3} !== 5'b10_000) begin
                bad++;
                $display("FAIL stall_hold%0d: got %b required 10000", i, {mem_write3, wb_valid3, ex_alu_src3});
            end
        end
        idle(1);
        tot++;
        if ({mem_write3, wb_valid3} !== 2'b01) begin
            bad++;
            $display("FAIL stall_release: got %b required 01", {mem_write3, wb_valid3});
        end
        idle(3);
        chk_empty("stall_drain");
    endtask

    task automatic test_flush();
        step(ST, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(ADDI, 1'b1, 1'b1, 1'b1);
        tot++;
        if ({mem_write3, ex_alu_src3, ex_invA3, ex_invB3, ex_cin3} !== 7'b1_000_000) begin
            bad++;
            $display("FAIL flush_stall: got %b required 1000000", {mem_write3, ex_alu_src3, ex_invA3, ex_invB3, ex_cin3});
        end
        step(ADDI, 1'b1, 1'b0, 1'b1);
        tot++;
        if ({ex_alu_src3, ex_invA3, ex_invB3, ex_cin3} !== 6'b0) begin
            bad++;
            $display("FAIL flush_only: got %b required 000000", {ex_alu_src3, ex_invA3, ex_invB3, ex_cin3});
        end
        idle(5);
        chk_empty("flush_drain");
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        for (int i = 0; i < 200; i++) begin
            op = 5'($urandom_range(1, 31));
            if (TRAP && op[4:1] == 4'b0001) op = 5'b00001;
            step({op, 9'($urandom), 2'($urandom)}, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end
        idle(6);
        chk_empty("b2b_drain");
    endtask

    task automatic test_illegal();
        step(ILL, 1'b1, 1'b0, 1'b0);
        tot++;
        if ({ex_alu_src3, ex_invA3, ex_invB3, ex_cin3, wb_valid3} !== 7'b0) begin
            bad++;
            $display("FAIL ill_bubble: got %b required 0000000", {ex_alu_src3, ex_invA3, ex_invB3, ex_cin3, wb_valid3});
        end
        step(ADD, 1'b1, 1'b0, 1'b0);
        idle(6);
        tot++;
        if ({err3, err4, halted3, halted4} !== {4{TRAP}}) begin
            bad++;
            $display("FAIL ill_state: got %b required %b", {err3, err4, halted3, halted4}, {4{TRAP}});
        end
        chk_empty("ill_drain");
    endtask

    task automatic test_halt();
        do_reset();
        step(HALT, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tot++;
            if ({dump3, halted3, dump4, halted4} !== {k == 3, k >= 4, k == 4, k >= 5}) begin
                bad++;
                $display("FAIL halt_c%0d: got %b required %b", k, {dump3, halted3, dump4, halted4}, {k == 3, k >= 4, k == 4, k >= 5});
            end
            step(ADD, 1'b1, 1'b0, 1'b0);
        end
        chk_empty("halt_drain");
    endtask

    task automatic test_halt_flush();
        do_reset();
        step(HALT, 1'b1, 1'b0, 1'b0);
        step(ADDI, 1'b1, 1'b0, 1'b1);
        step(ADDI, 1'b1, 1'b0, 1'b0);
        tot++;
        if ({ex_alu_src3, halted3} !== 4'b001_0) begin
            bad++;
            $display("FAIL hflush_run: got %b required 0010", {ex_alu_src3, halted3});
        end
        for (int i = 0; i < 5; i++) begin
            idle(1);
            tot++;
            if ({dump3, dump4, halted3, halted4} !== 4'b0) begin
                bad++;
                $display("FAIL hflush_nodump%0d: got %b required 0000", i, {dump3, dump4, halted3, halted4});
            end
        end
        chk_empty("hflush_drain");
    endtask

    task automatic test_reset_drain();
        do_reset();
        step(HALT, 1'b1, 1'b0, 1'b0);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        tot++;
        if (o3 !== 15'h0 || o4 !== 15'h0) begin
            bad++;
            $display("FAIL async_reset: got %h/%h required 0/0", o3, o4);
        end
        do_reset();
        step(ADD, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            tot++;
            if ({dump3, dump4, halted3, halted4} !== 4'b0) begin
                bad++;
                $display("FAIL rdrain_nodump%0d: got %b required 0000", i, {dump3, dump4, halted3, halted4});
            end
        end
        chk_empty("rdrain_drain");
    endtask

    initial begin
        test_reset();
        test_add();
        test_decode();
        test_stall();
        test_flush();
        test_back_to_back();
        test_illegal();
        test_halt();
        test_halt_flush();
        test_reset_drain();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 3, meaning the number of registered control stages after decode (legal 2..4); stage 1 is EX, stage STAGES-1 is MEM, stage STAGES is WB.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock, the block's only clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr  input  16  instruction; opcode = instr[15:11], function = instr[1:0].
REQ-005 in_valid  input  1  instr is a real instruction this cycle.
REQ-006 stall  input  1  freeze all stages.
REQ-007 flush  input  1  kill the instruction entering stage 1.
REQ-008 ex_alu_src  output  3,  ex_invA / ex_invB / ex_cin  output  1 each  stage-1 ALU controls.
REQ-009 mem_write  output  1  stage STAGES-1 memory write, qualified by that stage's valid.
REQ-010 wb_reg_write, wb_mem_to_reg  output  1 each;  wb_reg_dst  output  2  stage STAGES writeback controls, qualified by WB valid.
REQ-011 wb_valid  output  1;  dump  output  1;  halted  output  1;  err  output  1.

Function
REQ-012 SHALL decode: mem_write for 10000, 10011; mem_to_reg for 10001; reg_write for 010xx, 101xx, 10001, 10010, 10011, 11xxx, 00110, 00111.
REQ-013 SHALL decode reg_dst: 0 for 11xxx except 11000; 1 for 010xx, 101xx, 10001, 0000x; 2 for 10000, 10010, 10011, 11000, 011xx; 3 for 001xx.
REQ-014 SHALL decode alu_src: 1 for 01000, 01001, 10000, 10001, 10011; 2 for 01010, 01011, 101xx; 3 for 11000; 4 for 10010; 5 for 011xx; 0 for 11010, 11011, 111xx; 6 for 11001, 001xx; 7 for 0000x.
REQ-015 SHALL decode {invA,invB,cin}: 101 for 01001, 11101, and 11011 with function 01; 010 for 01011 and 11011 with function 11; 011 for 11100, 11110, 011xx; 000 otherwise.
REQ-016 SHALL treat opcodes 00010 and 00011 as illegal.
REQ-017 SHALL load the decoded control word and valid into stage 1 on each edge when stall=0; instruction valid = in_valid and state RUN.
REQ-018 SHALL advance stage k into stage k+1 on each edge when stall=0; latency decode to WB = STAGES cycles.
REQ-019 SHALL hold every stage unchanged while stall=1 and flush=0.
REQ-020 SHALL load a bubble (valid=0, all controls 0) into stage 1 when flush=1, regardless of stall; later stages follow REQ-018/019.
REQ-021 SHALL load an illegal opcode into stage 1 as a bubble.
REQ-022 SHALL implement FSM RUN -> DRAIN -> HALTED; RUN -> DRAIN when a valid HALT (00000) is loaded into stage 1.
REQ-023 SHALL, in DRAIN, treat in_valid as 0 and run a down-counter from STAGES-1, decremented on each non-stalled edge.
REQ-024 SHALL return DRAIN -> RUN if the HALT is flushed while still in stage 1 (flush during the first DRAIN cycle).
REQ-025 SHALL pulse dump for exactly one cycle when the HALT reaches WB (counter reaches 0 and HALT in WB), then enter HALTED.
REQ-026 SHALL, in HALTED, hold halted=1, load only bubbles, and leave HALTED only on reset.
REQ-027 SHALL drive zero on all gated outputs whose stage valid is 0.

Reset
REQ-028 SHALL, on rst_n low, immediately clear all stages to bubbles, set FSM to RUN, counter to 0, and err to 0.
REQ-029 SHALL drive every output to 0 during and after reset until the first valid instruction; reset mid-DRAIN returns to RUN with no dump.

Configuration
REQ-030 SHALL, with ILLEGAL_TRAP_EN defined, treat a valid illegal opcode entering stage 1 as HALT (REQ-022..026) and set err sticky-high until reset.
REQ-031 SHALL, without ILLEGAL_TRAP_EN, treat illegal opcodes as NOP bubbles and tie err to 0.

Verification
REQ-032 STAGES=3, ADD instr 0xD801 (11011, function 01) valid -> ex_invA=1, ex_cin=1 after 1 cycle; wb_reg_write=1, wb_reg_dst=0 after 3 cycles.
REQ-033 ST 10000 then stall=1 for 2 cycles -> mem_write held high for 3 cycles total; no stage advances during the stall.
REQ-034 ADDI with flush=1 and stall=1 on the same edge -> stage 1 is a bubble, and wb_valid stays 0 for that instruction.
REQ-035 HALT at cycle 0, STAGES=4, in_valid kept high -> dump=1 at cycle 4 only, halted=1 from cycle 5, no later instruction reaches WB.
REQ-036 HALT followed by flush on the next edge -> FSM back in RUN, dump never asserted, subsequent ADDI completes.
REQ-037 Opcode 00010 valid -> with ILLEGAL_TRAP_EN: err=1 and halted after drain; without it: bubble, err=0, pipeline continues.
